ram_bist: RTL and testbench

Built-in self-test engine that drives the single-port synchronous RAM (write-enable, read-enable, address, data-in, registered data-out) as its initiator. On a start pulse it runs a March C- sequence over every address, compares each read against the expected background and reports pass/fail with first-failure diagnostics. It sits between the system control logic and the RAM instance, which it owns for the duration of a test.

---
 rtl/ram_bist_pkg.sv | 45 ++++
 rtl/ram_bist_addr_gen.sv | 31 +++
 rtl/ram_bist.sv | 194 +++++++++++++++++++
 tb/tb_ram_bist.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types, march element table and background constants for ram_bist
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CMP,
    ST_FIN
  } state_e;

  localparam logic [2:0] ELEM_E0 = 3'd0;
  localparam logic [2:0] ELEM_E1 = 3'd1;
  localparam logic [2:0] ELEM_E2 = 3'd2;
  localparam logic [2:0] ELEM_E3 = 3'd3;
  localparam logic [2:0] ELEM_E4 = 3'd4;
  localparam logic [2:0] ELEM_E5 = 3'd5;

  // Background selector values: which of the two patterns of a pass is meant.
  localparam logic BG_ZERO = 1'b0;
  localparam logic BG_ONE  = 1'b1;

  // Per-element behaviour: address direction, value expected on read,
  // whether the element writes back, and the value it writes.
  typedef struct packed {
    logic up;
    logic rd_val;
    logic has_wr;
    logic wr_val;
  } elem_op_t;

  function automatic elem_op_t elem_op(input logic [2:0] e);
    elem_op_t op;
    case (e)
      ELEM_E0: op = '{up: 1'b1, rd_val: BG_ZERO, has_wr: 1'b1, wr_val: BG_ZERO};
      ELEM_E1: op = '{up: 1'b1, rd_val: BG_ZERO, has_wr: 1'b1, wr_val: BG_ONE};
      ELEM_E2: op = '{up: 1'b1, rd_val: BG_ONE,  has_wr: 1'b1, wr_val: BG_ZERO};
      ELEM_E3: op = '{up: 1'b0, rd_val: BG_ZERO, has_wr: 1'b1, wr_val: BG_ONE};
      ELEM_E4: op = '{up: 1'b0, rd_val: BG_ONE,  has_wr: 1'b1, wr_val: BG_ZERO};
      default: op = '{up: 1'b0, rd_val: BG_ZERO, has_wr: 1'b0, wr_val: BG_ZERO};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// rtl/ram_bist_addr_gen.sv - up/down address counter with load, enable and terminal-count flag
module ram_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  logic [ADDR_W-1:0] addr_q;

  // Load wins over count; counting wraps naturally at either end.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_val;
    end else if (en) begin
      addr_q <= up ? addr_q + 1'b1 : addr_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign tc   = up ? (&addr_q) : (~|addr_q);

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - March C- RAM BIST engine; RAM_BIST_CHECKERBOARD_EN adds a 55/AA second pass
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [3:0]        fail_elem,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q;
  logic [2:0]        elem_q;
  logic              bgp_q;
  logic              busy_q, done_q, pass_q, we_q, re_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q, din_q;
  logic [3:0]        fail_elem_q;

  logic              ag_load, ag_en, ag_tc;
  logic [ADDR_W-1:0] ag_load_val, ag_addr;
  elem_op_t          cur_op;
  logic              mismatch;

  // Background word: pass 0 is solid 0/1, pass 1 is the 55/AA checkerboard.
  function automatic logic [DATA_W-1:0] bg_word(input logic cb, input logic one);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W; i++) begin
      w[i] = cb ? (one ? i[0] : ~i[0]) : one;
    end
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] start_addr(input logic [2:0] e);
    return elem_op(e).up ? '0 : '1;
  endfunction

  assign cur_op   = elem_op(elem_q);
  assign mismatch = (state_q == ST_CMP) && (ram_dout != bg_word(bgp_q, cur_op.rd_val));

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (ag_en),
    .up       (cur_op.up),
    .addr     (ag_addr),
    .tc       (ag_tc)
  );

  // Address sequencing: reload at element boundaries, step after each access.
  always_comb begin
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_en       = 1'b0;
    case (state_q)
      ST_IDLE: ag_load = start;
      ST_WR: begin
        if (ag_tc) begin
          ag_load     = 1'b1;
          ag_load_val = start_addr(ELEM_E1);
        end else begin
          ag_en = 1'b1;
        end
      end
      ST_CMP: begin
        if (!mismatch) begin
          if (ag_tc) begin
            ag_load     = 1'b1;
            ag_load_val = (elem_q == ELEM_E5) ? start_addr(ELEM_E0) : start_addr(elem_q + 3'd1);
          end else begin
            ag_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Main test FSM with registered status and RAM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= ELEM_E0;
      bgp_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      din_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_WR;
            elem_q      <= ELEM_E0;
            bgp_q       <= 1'b0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
            we_q        <= 1'b1;
            din_q       <= bg_word(1'b0, BG_ZERO);
          end
        end
        ST_WR: begin
          if (ag_tc) begin
            state_q <= ST_RD;
            elem_q  <= ELEM_E1;
            we_q    <= 1'b0;
            re_q    <= 1'b1;
          end
        end
        ST_RD: begin
          state_q <= ST_CMP;
          re_q    <= 1'b0;
          we_q    <= cur_op.has_wr;
          din_q   <= bg_word(bgp_q, cur_op.wr_val);
        end
        ST_CMP: begin
          we_q <= 1'b0;
          if (mismatch) begin
            state_q     <= ST_FIN;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= ag_addr;
            fail_data_q <= ram_dout;
            fail_elem_q <= {bgp_q, elem_q};
          end else if (ag_tc && elem_q == ELEM_E5) begin
`ifdef RAM_BIST_CHECKERBOARD_EN
            if (!bgp_q) begin
              state_q <= ST_WR;
              elem_q  <= ELEM_E0;
              bgp_q   <= 1'b1;
              we_q    <= 1'b1;
              din_q   <= bg_word(1'b1, BG_ZERO);
            end else begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
`else
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
`endif
          end else begin
            state_q <= ST_RD;
            re_q    <= 1'b1;
            if (ag_tc) elem_q <= elem_q + 3'd1;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_elem = fail_elem_q;
  assign ram_re    = re_q;
  assign ram_addr  = ag_addr;
  assign ram_din   = din_q;
  // The write-back in CMP is decided before the read data arrives, so a
  // failing compare has to veto it in the same cycle.
  assign ram_we    = we_q & ~mismatch;

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - directed self-checking bench for ram_bist with a faultable 16x8 RAM model
module tb_ram_bist;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N      = 1 << ADDR_W;
`ifdef RAM_BIST_CHECKERBOARD_EN
  localparam int NPASS  = 2;
`else
  localparam int NPASS  = 1;
`endif
  localparam int FULL   = 11 * N * NPASS;

  logic              clk = 1'b0;
  logic              rst, start;
  logic              busy, done, pass, ram_we, ram_re;
  logic [ADDR_W-1:0] fail_addr, ram_addr;
  logic [DATA_W-1:0] fail_data, ram_din, ram_dout;
  logic [3:0]        fail_elem;

  int total = 0;
  int bad   = 0;
  int fault = 0;
  int overlap = 0;
  int cnt55 = 0;
  int cntaa = 0;
  logic [DATA_W-1:0] mem [N];

  ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic int eff(input logic [ADDR_W-1:0] a);
    if (fault == 2 && a == 4'd9) return 1;
    return int'(a);
  endfunction

  // RAM model: fault 1 = bit 3 of address 5 stuck at 0; fault 2 = address 9 aliased onto 1.
  always @(posedge clk) begin
    if (ram_we) mem[eff(ram_addr)] <= ram_din;
    if (ram_re) ram_dout <= (fault == 1 && eff(ram_addr) == 5) ? (mem[5] & 8'hF7) : mem[eff(ram_addr)];
  end

  always @(negedge clk) begin
    if (ram_we && ram_re) overlap++;
    if (ram_we && ram_din == 8'h55) cnt55++;
    if (ram_we && ram_din == 8'hAA) cntaa++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint outs();
    return longint'({busy, done, pass, fail_addr, fail_data, fail_elem, ram_we, ram_re, ram_addr, ram_din});
  endfunction

  // Pulse start, optionally re-pulse it mid-run, and measure busy/done/after-abort behaviour.
  task automatic run_one(input int repulse, output int bcnt, output int dfirst,
                         output int dcnt, output int post_acc, output int pfirst);
    int guard;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pfirst = int'(pass);
    bcnt = 0; guard = 0;
    while (busy && guard < 2000) begin
      bcnt++;
      start = (bcnt == repulse);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    dfirst = int'(done);
    dcnt = 0; post_acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      if (ram_we || ram_re) post_acc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string name;
    int    fault;
    int    exp_busy;
    int    exp_pass;
    int    exp_faddr;
    int    exp_fdata;
    int    exp_felem;
  } vec_t;

  vec_t vecs[3];
  int bcnt, dfirst, dcnt, post_acc, pfirst;

  initial begin
    vecs[0] = '{"good",    0, FULL, 1, 0, 0,     0};
    vecs[1] = '{"stuck",   1, 60,   0, 5, 'hF7, 2};
    vecs[2] = '{"alias",   2, 36,   0, 9, 'hFF, 1};
    for (int i = 0; i < N; i++) mem[i] = '0;
    ram_dout = '0;

    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      fault = vecs[v].fault;
      cnt55 = 0; cntaa = 0;
      run_one(0, bcnt, dfirst, dcnt, post_acc, pfirst);
      chk({vecs[v].name, "_busy"},      bcnt, vecs[v].exp_busy);
      chk({vecs[v].name, "_done_next"}, dfirst, 1);
      chk({vecs[v].name, "_done_once"}, dcnt, 1);
      chk({vecs[v].name, "_pass"},      pass, vecs[v].exp_pass);
      chk({vecs[v].name, "_faddr"},     fail_addr, vecs[v].exp_faddr);
      chk({vecs[v].name, "_fdata"},     fail_data, vecs[v].exp_fdata);
      chk({vecs[v].name, "_felem"},     fail_elem, vecs[v].exp_felem);
      chk({vecs[v].name, "_quiet"},     post_acc, 0);
      if (v == 0) begin
        chk("good_writes55", cnt55, (NPASS == 2) ? 3 * N : 0);
        chk("good_writesAA", cntaa, (NPASS == 2) ? 2 * N : 0);
      end
    end

    fault = 0;
    run_one(20, bcnt, dfirst, dcnt, post_acc, pfirst);
    chk("repulse_busy", bcnt, FULL);
    chk("repulse_pass", pass, 1);
    run_one(0, bcnt, dfirst, dcnt, post_acc, pfirst);
    chk("restart_pass_cleared", pfirst, 0);
    chk("restart_busy", bcnt, FULL);
    chk("restart_pass", pass, 1);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", outs(), 0);
    rst = 1'b0;
    run_one(0, bcnt, dfirst, dcnt, post_acc, pfirst);
    chk("after_reset_busy", bcnt, FULL);
    chk("after_reset_pass", pass, 1);

    chk("we_re_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
